riscv_vec_mem_sched: RTL and testbench
======================================

RISCV_VEC_MEM_SCHED -- requirements
Module: riscv_vec_mem_sched

Interface
REQ-001 SHALL have parameter ADDR_STRIDE, default 32'h1, meaning the address increment between consecutive lanes.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports req_val input 1 and req_rdy output 1: core-side vector memory request handshake.
REQ-005 SHALL have ports req_rw input 1 (1=store), req_len input 3 ({vector flag, 2-bit len}), req_addr input 32, req_vl input 4, req_data input 256 (lane i = bits 32i+31:32i).
REQ-006 SHALL have ports resp_val output 1, resp_rdy input 1, resp_data output 256: completion handshake with gathered lane data.
REQ-007 SHALL have port busy, output, 1: high whenever the block is not in IDLE.
REQ-008 SHALL have ports lane_req_val output 8 and lane_req_rdy input 8: independent per-lane memory request handshakes.
REQ-009 SHALL have ports lane_req_rw output 1, lane_req_len output 2, lane_req_addr output 256, lane_req_data output 256.
REQ-010 SHALL have ports lane_resp_val input 8 and lane_resp_data input 256: per-lane memory responses.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE; req_rdy=1 only in IDLE.
REQ-012 SHALL, on req_val&&req_rdy, register rw, len, addr, data and the active-lane mask, then enter BUSY the next cycle.
REQ-013 SHALL compute the active mask as lanes i<min(req_vl,8) when req_len[2]=1, lane 0 only when req_len[2]=0; req_vl=0 with req_len[2]=1 yields an empty mask.
REQ-014 SHALL, with an empty mask, go IDLE->DONE directly, issuing no lane requests.
REQ-015 SHALL drive lane_req_addr lane i = registered addr + i*ADDR_STRIDE (32-bit, wrap modulo 2^32), lane_req_data lane i = registered data lane i, lane_req_rw/len from registered values.
REQ-016 SHALL in BUSY assert lane_req_val[i] for every active lane whose issued bit is clear; the lane's issued bit sets on lane_req_val[i]&&lane_req_rdy[i], and lane_req_val[i] drops the next cycle.
REQ-017 SHALL let each lane fire independently; a lane with lane_req_rdy low holds val and stable addr/data without blocking other lanes.
REQ-018 SHALL capture lane_resp_data[i] and set received bit i only when lane_resp_val[i] is high and issued bit i was already set at the start of the cycle; other responses are ignored.
REQ-019 SHALL transition BUSY->DONE the cycle after received mask equals active mask.
REQ-020 SHALL assert resp_val in DONE, holding resp_data stable until resp_rdy; on resp_val&&resp_rdy return to IDLE next cycle.
REQ-021 SHALL drive resp_data lane i = captured data for active lanes and zero for inactive lanes, for loads and stores alike.
REQ-022 SHALL, with all lane_req_rdy=1 and responses one cycle after fire, produce resp_val 3 cycles after request acceptance.
REQ-023 SHALL keep lane_req_val=0 outside BUSY and SHALL accept no new request until DONE completes.

Reset
REQ-024 SHALL, while reset is high, force state IDLE, issued/received masks and captured data to zero, lane_req_val=0, resp_val=0, busy=0, req_rdy=0.
REQ-025 SHALL assert req_rdy=1 the first cycle after reset deasserts; reset mid-operation discards the in-flight request and later lane responses are ignored.

Verification
REQ-026 Load, vl=8, addr=0x100, all rdy, responses 0x10+i next cycle -> lane addrs 0x100..0x107, resp_val cycle 3, resp_data lane i=0x10+i.
REQ-027 Store, vl=3, lane_req_rdy[1]=0 for 4 cycles -> lanes 0,2 fire cycle 1, lane 1 holds val/addr 0x101 until rdy; resp_data lanes 3-7 zero.
REQ-028 Scalar load (req_len=3'b010, vl=5) -> only lane_req_val[0] asserted; resp_data[255:32]=0.
REQ-029 req_vl=0 vector -> no lane_req_val ever; resp_val one cycle after acceptance.
REQ-030 resp_rdy held low 5 cycles in DONE -> resp_val/resp_data stable, req_rdy=0; spurious lane_resp_val in IDLE has no effect.
REQ-031 Reset asserted in BUSY with lane 2 outstanding -> lane_req_val=0 immediately; after release new request 0x200 vl=1 completes with correct data.

Source files
------------

// File: rtl/riscv_vec_mem_sched.sv
// riscv_vec_mem_sched
// Splits one core-side vector memory request into up to eight independent
// per-lane memory requests. It gathers each lane's response and returns a
// single completion that carries the gathered lane data.
//
// Ports
//   clk, reset         : clock and asynchronous active-high reset
//   req_*              : core request handshake; the payload is registered on acceptance
//                        (rw, {vector flag, len}, base addr, vector length, data)
//   resp_val/rdy/data  : completion handshake; lane i of resp_data is the
//                        captured response for active lanes and zero for the rest
//   busy               : high whenever the scheduler is not idle
//   lane_req_*         : per-lane request valid/ready plus shared rw/len and
//                        per-lane address/data (lane i = bits 32i+31:32i)
//   lane_resp_val/data : per-lane memory responses
module riscv_vec_mem_sched #(
    parameter logic [31:0] ADDR_STRIDE = 32'h1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_val,
    output logic         req_rdy,
    input  logic         req_rw,
    input  logic [2:0]   req_len,
    input  logic [31:0]  req_addr,
    input  logic [3:0]   req_vl,
    input  logic [255:0] req_data,
    output logic         resp_val,
    input  logic         resp_rdy,
    output logic [255:0] resp_data,
    output logic         busy,
    output logic [7:0]   lane_req_val,
    input  logic [7:0]   lane_req_rdy,
    output logic         lane_req_rw,
    output logic [1:0]   lane_req_len,
    output logic [255:0] lane_req_addr,
    output logic [255:0] lane_req_data,
    input  logic [7:0]   lane_resp_val,
    input  logic [255:0] lane_resp_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           rw_q, rw_d;
    logic [1:0]     len_q, len_d;
    logic [31:0]    addr_q, addr_d;
    logic [255:0]   data_q, data_d;
    logic [7:0]     active_q, active_d;
    logic [7:0]     issued_q, issued_d;
    logic [7:0]     received_q, received_d;
    logic [255:0]   capt_q, capt_d;
    logic [7:0]     lane_val_s;
    logic [7:0]     new_mask_s;

    // A vector request covers lanes below min(vl, 8). A scalar request covers lane 0 only.
    function automatic logic [7:0] lane_mask(input logic [2:0] len, input logic [3:0] vl);
        logic [7:0] mask;
        mask = 8'h00;
        if (len[2]) begin
            for (int i = 0; i < 8; i++) begin
                if (i < int'(vl)) begin
                    mask[i] = 1'b1;
                end else begin
                    mask[i] = 1'b0;
                end
            end
        end else begin
            mask = 8'h01;
        end
        return mask;
    endfunction

    assign new_mask_s = lane_mask(req_len, req_vl);

    // Handshake outputs decode directly from the state register.
    assign req_rdy      = (state_q == IDLE) && !reset;
    assign resp_val     = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign lane_req_val = lane_val_s;
    assign lane_req_rw  = rw_q;
    assign lane_req_len = len_q;
    assign lane_req_data = data_q;

    // Next-state logic: acceptance, per-lane issue/receive tracking, and completion.
    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        len_d      = len_q;
        addr_d     = addr_q;
        data_d     = data_q;
        active_d   = active_q;
        issued_d   = issued_q;
        received_d = received_q;
        capt_d     = capt_q;
        lane_val_s = 8'h00;
        case (state_q)
            IDLE: begin
                if (req_val && req_rdy) begin
                    rw_d       = req_rw;
                    len_d      = req_len[1:0];
                    addr_d     = req_addr;
                    data_d     = req_data;
                    active_d   = new_mask_s;
                    issued_d   = 8'h00;
                    received_d = 8'h00;
                    capt_d     = 256'h0;
                    // An empty mask has nothing to issue, so it completes immediately.
                    if (new_mask_s == 8'h00) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                lane_val_s = active_q & ~issued_q;
                issued_d   = issued_q | (lane_val_s & lane_req_rdy);
                // Only lanes issued before this cycle may return data. This covers
                // responses that arrive in the same cycle as the request fires.
                for (int i = 0; i < 8; i++) begin
                    if (lane_resp_val[i] && issued_q[i]) begin
                        received_d[i]       = 1'b1;
                        capt_d[32*i +: 32]  = lane_resp_data[32*i +: 32];
                    end else begin
                        received_d[i]       = received_q[i];
                    end
                end
                // Compare the updated mask so that the last response moves the state to DONE on this edge.
                if (received_d == active_q) begin
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (resp_rdy) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-lane address generation; the sum wraps modulo 2^32.
    always_comb begin
        lane_req_addr = 256'h0;
        for (int i = 0; i < 8; i++) begin
            lane_req_addr[32*i +: 32] = addr_q + (32'(i) * ADDR_STRIDE);
        end
    end

    // Gathered completion data; inactive lanes read as zero.
    always_comb begin
        resp_data = 256'h0;
        for (int i = 0; i < 8; i++) begin
            if (active_q[i]) begin
                resp_data[32*i +: 32] = capt_q[32*i +: 32];
            end else begin
                resp_data[32*i +: 32] = 32'h0;
            end
        end
    end

    // State and payload registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rw_q       <= 1'b0;
            len_q      <= 2'b00;
            addr_q     <= 32'h0;
            data_q     <= 256'h0;
            active_q   <= 8'h00;
            issued_q   <= 8'h00;
            received_q <= 8'h00;
            capt_q     <= 256'h0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            active_q   <= active_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            capt_q     <= capt_d;
        end
    end

endmodule

// File: tb/tb_riscv_vec_mem_sched.sv
// Self-checking bench for riscv_vec_mem_sched. It runs directed table vectors,
// hand-written stall and reset sequences, and randomized transactions.
// A behavioural lane memory responds to the DUT, and expectations come from the request rules.
module tb_riscv_vec_mem_sched;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_val;
    logic         req_rdy;
    logic         req_rw;
    logic [2:0]   req_len;
    logic [31:0]  req_addr;
    logic [3:0]   req_vl;
    logic [255:0] req_data;
    logic         resp_val;
    logic         resp_rdy;
    logic [255:0] resp_data;
    logic         busy;
    logic [7:0]   lane_req_val;
    logic [7:0]   lane_req_rdy;
    logic         lane_req_rw;
    logic [1:0]   lane_req_len;
    logic [255:0] lane_req_addr;
    logic [255:0] lane_req_data;
    logic [7:0]   lane_resp_val;
    logic [255:0] lane_resp_data;

    riscv_vec_mem_sched dut (
        .clk            (clk),
        .reset          (reset),
        .req_val        (req_val),
        .req_rdy        (req_rdy),
        .req_rw         (req_rw),
        .req_len        (req_len),
        .req_addr       (req_addr),
        .req_vl         (req_vl),
        .req_data       (req_data),
        .resp_val       (resp_val),
        .resp_rdy       (resp_rdy),
        .resp_data      (resp_data),
        .busy           (busy),
        .lane_req_val   (lane_req_val),
        .lane_req_rdy   (lane_req_rdy),
        .lane_req_rw    (lane_req_rw),
        .lane_req_len   (lane_req_len),
        .lane_req_addr  (lane_req_addr),
        .lane_req_data  (lane_req_data),
        .lane_resp_val  (lane_resp_val),
        .lane_resp_data (lane_resp_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int fire_cyc [8];
    int fire_cnt [8];
    int lat;

    typedef struct {
        logic        rw;
        logic [2:0]  len;
        logic [31:0] addr;
        logic [3:0]  vl;
        logic [31:0] base;
        logic [7:0]  exp_mask;
        int          exp_lat;
        int          resp_wait;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference rule: number of lanes = min(vl,8) for vectors, 1 for scalars.
    function automatic logic [7:0] model_mask(input logic [2:0] len, input logic [3:0] vl);
        int n;
        n = len[2] ? ((vl > 4'd8) ? 8 : int'(vl)) : 1;
        return 8'((1 << n) - 1);
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // One full transaction against the behavioural lane memory (responds base+i).
    task automatic run_txn(input logic rw, input logic [2:0] len, input logic [31:0] addr,
                           input logic [3:0] vl, input logic [255:0] data, input logic [31:0] base,
                           input logic [7:0] exp_mask, input int exp_lat, input int rdy_pct,
                           input int max_dly, input logic [7:0] stall_mask, input int stall_cyc,
                           input int resp_wait);
        int due [8];
        int verr;
        bit ok;
        logic [7:0] rdy;
        logic [255:0] exp_data;
        logic [255:0] held;
        for (int i = 0; i < 8; i++) begin
            fire_cyc[i] = -1;
            fire_cnt[i] = 0;
            due[i] = -1;
            exp_data[32*i +: 32] = exp_mask[i] ? (base + 32'(i)) : 32'h0;
        end
        chk(req_rdy === 1'b1 && busy === 1'b0, "idle_before_req", {req_rdy, busy}, 2'b10);
        req_val = 1'b1; req_rw = rw; req_len = len; req_addr = addr; req_vl = vl; req_data = data;
        @(posedge clk); #1;
        req_val = 1'b0; req_addr = $urandom; req_data = rand256(); req_rw = ~rw; req_len = ~len;
        verr = 0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            if (resp_val === 1'b1) begin
                lat = c;
                break;
            end
            if ((lane_req_val & ~exp_mask) != 8'h00) verr++;
            if (busy !== 1'b1 || req_rdy !== 1'b0) verr++;
            for (int i = 0; i < 8; i++) begin
                if (exp_mask[i] && fire_cyc[i] < 0 && lane_req_val[i] !== 1'b1) verr++;
                if (fire_cyc[i] >= 0 && lane_req_val[i] !== 1'b0) verr++;
                if (lane_req_val[i] === 1'b1) begin
                    if (lane_req_addr[32*i +: 32] !== addr + 32'(i)) verr++;
                    if (lane_req_data[32*i +: 32] !== data[32*i +: 32]) verr++;
                    if (lane_req_rw !== rw || lane_req_len !== len[1:0]) verr++;
                end
            end
            // Lane memory: deliver due responses, inject junk on never-issued lanes.
            for (int i = 0; i < 8; i++) begin
                if (due[i] == c) begin
                    lane_resp_val[i] = 1'b1;
                    lane_resp_data[32*i +: 32] = base + 32'(i);
                end else if (fire_cyc[i] < 0 && $urandom_range(3) == 0) begin
                    lane_resp_val[i] = 1'b1;
                    lane_resp_data[32*i +: 32] = 32'hDEAD0000 | 32'(i);
                end else begin
                    lane_resp_val[i] = 1'b0;
                end
            end
            for (int i = 0; i < 8; i++) begin
                rdy[i] = ($urandom_range(99) < rdy_pct);
                if (stall_mask[i] && c <= stall_cyc) rdy[i] = 1'b0;
                if (lane_req_val[i] === 1'b1 && rdy[i]) begin
                    fire_cnt[i]++;
                    if (fire_cyc[i] < 0) fire_cyc[i] = c;
                    due[i] = c + 1 + int'($urandom_range(max_dly - 1));
                end
            end
            lane_req_rdy = rdy;
            @(posedge clk); #1;
        end
        lane_req_rdy = 8'h00;
        lane_resp_val = 8'h00;
        if (lat < 0) begin
            chk(1'b0, "timeout_resp_val", 0, 1);
            reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
            return;
        end
        chk(verr == 0, "lane_req_behaviour", verr, 0);
        ok = 1'b1;
        for (int i = 0; i < 8; i++) if (fire_cnt[i] != (exp_mask[i] ? 1 : 0)) ok = 1'b0;
        chk(ok, "fire_once_mask", 0, exp_mask);
        if (exp_lat >= 0) chk(lat == exp_lat, "latency", lat, exp_lat);
        chk(resp_data === exp_data, "resp_data", resp_data, exp_data);
        chk(busy === 1'b1 && req_rdy === 1'b0 && lane_req_val === 8'h00, "done_state",
            {busy, req_rdy, lane_req_val}, {2'b10, 8'h00});
        held = resp_data;
        ok = 1'b1;
        for (int k = 0; k < resp_wait; k++) begin
            lane_resp_val = $urandom; lane_resp_data = rand256();
            @(posedge clk); #1;
            if (resp_val !== 1'b1 || resp_data !== held || req_rdy !== 1'b0 || lane_req_val !== 8'h00) ok = 1'b0;
        end
        if (resp_wait > 0) chk(ok, "resp_hold", resp_data, held);
        lane_resp_val = 8'h00;
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        chk(busy === 1'b0 && resp_val === 1'b0 && req_rdy === 1'b1, "back_idle",
            {busy, resp_val, req_rdy}, 3'b001);
        lane_resp_val = $urandom; lane_resp_data = rand256();
        @(posedge clk); #1;
        lane_resp_val = 8'h00;
        chk(busy === 1'b0 && resp_val === 1'b0 && req_rdy === 1'b1 && lane_req_val === 8'h00,
            "idle_spurious", {busy, resp_val, req_rdy, lane_req_val}, 11'h100);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rl;
        logic [3:0]  rv;
        reset = 1'b1; req_val = 1'b0; req_rw = 1'b0; req_len = 3'b000; req_addr = 32'h0;
        req_vl = 4'h0; req_data = 256'h0; resp_rdy = 1'b0; lane_req_rdy = 8'h00;
        lane_resp_val = 8'h00; lane_resp_data = 256'h0;

        tbl[0] = '{1'b0, 3'b100, 32'h00000100, 4'd8,  32'h00000010, 8'hFF, 3, 0};
        tbl[1] = '{1'b0, 3'b010, 32'h00004000, 4'd5,  32'h00000077, 8'h01, 3, 1};
        tbl[2] = '{1'b0, 3'b110, 32'h00000500, 4'd0,  32'h00001234, 8'h00, 1, 2};
        tbl[3] = '{1'b0, 3'b101, 32'hFFFFFFFC, 4'd12, 32'hA0000000, 8'hFF, 3, 0};
        tbl[4] = '{1'b1, 3'b111, 32'h00000020, 4'd5,  32'h55550000, 8'h1F, 3, 5};
        tbl[5] = '{1'b0, 3'b001, 32'h00000040, 4'd0,  32'h00C0FFEE, 8'h01, 3, 0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk(req_rdy === 1'b0 && busy === 1'b0 && resp_val === 1'b0 && lane_req_val === 8'h00
            && resp_data === 256'h0, "reset_outputs", {req_rdy, busy, resp_val, lane_req_val}, 11'h0);
        reset = 1'b0;
        #1;
        chk(req_rdy === 1'b1 && busy === 1'b0, "rdy_after_reset", {req_rdy, busy}, 2'b10);
        @(posedge clk); #1;

        // Directed table with all lanes ready and one-cycle responses.
        for (int t = 0; t < 6; t++) begin
            run_txn(tbl[t].rw, tbl[t].len, tbl[t].addr, tbl[t].vl, rand256(), tbl[t].base,
                    tbl[t].exp_mask, tbl[t].exp_lat, 100, 1, 8'h00, 0, tbl[t].resp_wait);
        end

        // Store with lane 1 stalled for four cycles.
        run_txn(1'b1, 3'b110, 32'h00000100, 4'd3, rand256(), 32'h30000000, 8'h07, -1,
                100, 1, 8'h02, 4, 5);
        chk(fire_cyc[0] == 1 && fire_cyc[2] == 1 && fire_cyc[1] == 5, "stall_fire_cycles",
            {fire_cyc[0][7:0], fire_cyc[1][7:0], fire_cyc[2][7:0]}, 24'h010501);

        // Reset while lane 2 is outstanding.
        req_val = 1'b1; req_rw = 1'b0; req_len = 3'b100; req_addr = 32'h300; req_vl = 4'd3;
        req_data = rand256();
        @(posedge clk); #1;
        req_val = 1'b0;
        chk(lane_req_val === 8'h07, "rst_seq_issue", lane_req_val, 8'h07);
        lane_req_rdy = 8'h03;
        @(posedge clk); #1;
        lane_req_rdy = 8'h00;
        chk(lane_req_val === 8'h04, "rst_seq_outstanding", lane_req_val, 8'h04);
        lane_resp_val = 8'h03; lane_resp_data = rand256();
        reset = 1'b1;
        #1;
        chk(lane_req_val === 8'h00 && busy === 1'b0 && req_rdy === 1'b0 && resp_val === 1'b0
            && resp_data === 256'h0, "rst_seq_immediate", {lane_req_val, busy, req_rdy, resp_val}, 11'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        lane_resp_val = 8'h04; lane_resp_data = rand256();
        #1;
        chk(req_rdy === 1'b1 && busy === 1'b0, "rst_seq_release", {req_rdy, busy}, 2'b10);
        @(posedge clk); #1;
        lane_resp_val = 8'h00;
        chk(busy === 1'b0 && req_rdy === 1'b1 && lane_req_val === 8'h00, "rst_seq_stray_resp",
            {busy, req_rdy, lane_req_val}, 10'h100);
        run_txn(1'b0, 3'b100, 32'h00000200, 4'd1, rand256(), 32'h0000ABC0, 8'h01, 3,
                100, 1, 8'h00, 0, 0);

        // Randomized traffic against the reference rules.
        for (int t = 0; t < 40; t++) begin
            rl = 3'($urandom);
            rv = 4'($urandom);
            run_txn(1'($urandom), rl, $urandom, rv, rand256(), $urandom, model_mask(rl, rv), -1,
                    60, 3, 8'h00, 0, int'($urandom_range(3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
